// File: rtl/cpu_storebuffer_drain.sv
// rtl/cpu_storebuffer_drain.sv - drains store buffer head entries into a direct-mapped write-back data cache
// Hits write in the same cycle; misses evict a dirty victim, fetch and install the line, then retry.
module cpu_storebuffer_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES  = 64,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_WIDTH - 4 - IDX_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sb_empty,
  input  logic [ADDR_WIDTH-1:0] sb_tag,
  input  logic [WORD_WIDTH-1:0] sb_data,
  input  logic [3:0]            sb_bytes,
  output logic                  sb_pop,
  input  logic                  port_grant,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_hit,
  input  logic                  cache_victim_dirty,
  input  logic [TAG_W-1:0]      cache_victim_tag,
  input  logic [LINE_WIDTH-1:0] cache_victim_data,
  output logic                  cache_wr_en,
  output logic [1:0]            cache_wr_word,
  output logic [WORD_WIDTH-1:0] cache_wr_data,
  output logic [3:0]            cache_wr_bytes,
  output logic                  cache_fill_en,
  output logic [LINE_WIDTH-1:0] cache_fill_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rvalid,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_LOOKUP,
    S_WB_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_FILL_WRITE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] victim_addr_q, victim_addr_d;
  logic [LINE_WIDTH-1:0] victim_data_q, victim_data_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic store_go;
  assign store_go = !sb_empty && port_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_LOOKUP;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      line_q        <= '0;
    end else begin
      state_q       <= state_d;
      victim_addr_q <= victim_addr_d;
      victim_data_q <= victim_data_d;
      line_q        <= line_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_addr_d = victim_addr_q;
    victim_data_d = victim_data_q;
    line_d        = line_q;
    unique case (state_q)
      S_LOOKUP: begin
        if (store_go && !cache_hit) begin
          victim_addr_d = {cache_victim_tag, sb_tag[4 +: IDX_W], 4'b0000};
          victim_data_d = cache_victim_data;
          state_d       = cache_victim_dirty ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        if (mem_req_ready) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          line_d  = mem_rdata;
          state_d = S_FILL_WRITE;
        end
      end
      S_FILL_WRITE: begin
        if (port_grant) state_d = S_LOOKUP;
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  // Outputs are forced quiet while reset is held so nothing leaks out before the state register settles.
  always_comb begin
    cache_addr      = sb_tag;
    sb_pop          = 1'b0;
    cache_wr_en     = 1'b0;
    cache_wr_word   = 2'b00;
    cache_wr_data   = '0;
    cache_wr_bytes  = 4'b0000;
    cache_fill_en   = 1'b0;
    cache_fill_data = '0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    busy            = 1'b0;
    if (!reset) begin
      busy = (state_q != S_LOOKUP) || !sb_empty;
      unique case (state_q)
        S_LOOKUP: begin
          if (store_go && cache_hit) begin
            sb_pop         = 1'b1;
            cache_wr_en    = 1'b1;
            cache_wr_word  = sb_tag[3:2];
            cache_wr_data  = sb_data;
            cache_wr_bytes = sb_bytes;
          end
        end
        S_WB_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = victim_addr_q;
          mem_req_wdata = victim_data_q;
        end
        S_FILL_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {sb_tag[ADDR_WIDTH-1:4], 4'b0000};
        end
        S_FILL_WRITE: begin
          if (port_grant) begin
            cache_fill_en   = 1'b1;
            cache_fill_data = line_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_storebuffer_drain.sv
// tb/tb_cpu_storebuffer_drain.sv - scoreboard bench for cpu_storebuffer_drain
// Emulates the store buffer, cache arrays and memory; a reference cache model predicts the event stream.
module tb_cpu_storebuffer_drain;

  localparam int AW = 16;
  localparam int NL = 4;
  localparam int K_WB = 0, K_RD = 1, K_FILL = 2, K_WR = 3;

  typedef struct {
    int           kind;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [3:0]   bytes;
  } ev_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  bytes;
  } sb_t;

  logic         clock, reset;
  logic         sb_empty, sb_pop, port_grant;
  logic [15:0]  sb_tag, cache_addr, mem_req_addr;
  logic [31:0]  sb_data, cache_wr_data;
  logic [3:0]   sb_bytes, cache_wr_bytes;
  logic         cache_hit, cache_victim_dirty, cache_wr_en, cache_fill_en;
  logic [9:0]   cache_victim_tag;
  logic [127:0] cache_victim_data, cache_fill_data, mem_req_wdata, mem_rdata;
  logic [1:0]   cache_wr_word;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_rvalid, busy;

  cpu_storebuffer_drain #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .LINE_WIDTH(128), .NUM_LINES(NL)) dut (
    .clock(clock), .reset(reset), .sb_empty(sb_empty), .sb_tag(sb_tag), .sb_data(sb_data),
    .sb_bytes(sb_bytes), .sb_pop(sb_pop), .port_grant(port_grant), .cache_addr(cache_addr),
    .cache_hit(cache_hit), .cache_victim_dirty(cache_victim_dirty),
    .cache_victim_tag(cache_victim_tag), .cache_victim_data(cache_victim_data),
    .cache_wr_en(cache_wr_en), .cache_wr_word(cache_wr_word), .cache_wr_data(cache_wr_data),
    .cache_wr_bytes(cache_wr_bytes), .cache_fill_en(cache_fill_en),
    .cache_fill_data(cache_fill_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Environment cache arrays (written only by DUT write/fill outputs) and memory.
  logic         e_valid[NL], e_dirty[NL];
  logic [9:0]   e_tag[NL];
  logic [127:0] e_data[NL];
  logic [127:0] e_mem[int];
  // Reference model state.
  logic         r_valid[NL], r_dirty[NL];
  logic [9:0]   r_tag[NL];
  logic [127:0] r_data[NL];
  logic [127:0] r_mem[int];
  logic         s_valid[NL], s_dirty[NL];
  logic [9:0]   s_tag[NL];
  logic [127:0] s_data[NL];

  sb_t sb_q[$];
  ev_t exp_q[$];

  int  grant_pct, ready_pct, grant_low;
  bit  auto_rvalid, junk_en, hold_on_rvalid, rd_pend, rd_seen;
  int  rd_cnt;
  logic [15:0] rd_addr;

  logic [1:0] cidx;
  assign cidx               = cache_addr[5:4];
  assign cache_hit          = e_valid[cidx] && (e_tag[cidx] == cache_addr[15:6]);
  assign cache_victim_dirty = e_valid[cidx] && e_dirty[cidx];
  assign cache_victim_tag   = e_tag[cidx];
  assign cache_victim_data  = e_data[cidx];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [127:0] mem_init(input int a);
    return {32'(a * 3 + 1), 32'(a ^ 32'h5a5a), 32'(~a), 32'(a + 7)};
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] w,
                                             input logic [31:0] d, input logic [3:0] be);
    logic [127:0] r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[int'(w) * 32 + b * 8 +: 8] = d[b * 8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic update_sb();
    sb_empty = (sb_q.size() == 0);
    if (sb_q.size() != 0) begin
      sb_tag   = sb_q[0].addr;
      sb_data  = sb_q[0].data;
      sb_bytes = sb_q[0].bytes;
    end
  endtask

  task automatic push_ev(input int k, input logic [15:0] a, input logic [127:0] d, input logic [3:0] be);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.bytes = be;
    exp_q.push_back(e);
  endtask

  // Reference: a direct-mapped write-back, write-allocate cache in front of a flat line memory.
  task automatic predict(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    int la;
    int va;
    logic [127:0] line;
    idx = int'(a[5:4]);
    la  = int'({a[15:4], 4'b0000});
    if (!(r_valid[idx] && r_tag[idx] == a[15:6])) begin
      if (r_valid[idx] && r_dirty[idx]) begin
        va = int'({r_tag[idx], 2'(idx), 4'b0000});
        r_mem[va] = r_data[idx];
        push_ev(K_WB, 16'(va), r_data[idx], 4'b0000);
      end
      push_ev(K_RD, 16'(la), 128'd0, 4'b0000);
      line = r_mem.exists(la) ? r_mem[la] : mem_init(la);
      push_ev(K_FILL, 16'(la), line, 4'b0000);
      r_valid[idx] = 1'b1; r_dirty[idx] = 1'b0; r_tag[idx] = a[15:6]; r_data[idx] = line;
    end
    push_ev(K_WR, a, {96'd0, d}, be);
    r_data[idx]  = put_word(r_data[idx], a[3:2], d, be);
    r_dirty[idx] = 1'b1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    sb_t s;
    predict(a, d, be);
    s.addr = a; s.data = d; s.bytes = be;
    sb_q.push_back(s);
    update_sb();
  endtask

  task automatic preload(input int idx, input logic [9:0] t, input bit dirty, input logic [127:0] d);
    e_valid[idx] = 1'b1; e_dirty[idx] = dirty; e_tag[idx] = t; e_data[idx] = d;
    r_valid[idx] = 1'b1; r_dirty[idx] = dirty; r_tag[idx] = t; r_data[idx] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && sb_empty && !busy) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (!(exp_q.size() == 0 && sb_empty && !busy)) begin
      failures++;
      $display("FAIL %s timeout actual_pending=%0d required_pending=0", nm, exp_q.size());
    end
  endtask

  task automatic check_ev(input ev_t g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected actual_kind=%0d addr=%h required=none", g.kind, g.addr);
    end else begin
      e = exp_q.pop_front();
      if (g.kind != e.kind || g.addr !== e.addr || g.data !== e.data ||
          (e.kind == K_WR && g.bytes !== e.bytes)) begin
        failures++;
        $display("FAIL event kind actual=%0d required=%0d addr actual=%h required=%h data actual=%h required=%h bytes actual=%h required=%h",
                 g.kind, e.kind, g.addr, e.addr, g.data, e.data, g.bytes, e.bytes);
      end
    end
  endtask

  // Monitor: turns DUT activity into events and checks handshake rules.
  initial begin
    bit          pend;
    logic [15:0] pend_addr;
    logic        pend_we;
    ev_t         g;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 1'b0;
      end else begin
        chk("pop_equals_write", {126'd0, sb_pop, sb_empty && sb_pop}, {126'd0, cache_wr_en, 1'b0});
        if (pend) chk("req_held_stable", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, pend_we, pend_addr});
        if (cache_wr_en || cache_fill_en) chk("cache_activity_needs_grant", {127'd0, port_grant}, 128'd1);
        if (mem_req_valid && mem_req_ready) begin
          g.kind  = mem_req_we ? K_WB : K_RD;
          g.addr  = mem_req_addr;
          g.data  = mem_req_we ? mem_req_wdata : 128'd0;
          g.bytes = 4'b0000;
          check_ev(g);
        end
        if (cache_fill_en) begin
          g.kind = K_FILL; g.addr = {cache_addr[15:4], 4'b0000};
          g.data = cache_fill_data; g.bytes = 4'b0000;
          check_ev(g);
        end
        if (cache_wr_en) begin
          g.kind = K_WR; g.addr = {cache_addr[15:4], cache_wr_word, cache_addr[1:0]};
          g.data = {96'd0, cache_wr_data}; g.bytes = cache_wr_bytes;
          check_ev(g);
        end
        pend      = mem_req_valid && !mem_req_ready;
        pend_addr = mem_req_addr;
        pend_we   = mem_req_we;
      end
    end
  end

  // Environment: store buffer pops, cache array updates, memory responder, grant/ready drivers.
  initial begin
    logic x_rst, x_pop, x_wr, x_fill, x_mv, x_mr, x_we, acc;
    logic [15:0] x_addr, x_maddr;
    logic [1:0] x_word;
    logic [31:0] x_wd;
    logic [3:0] x_be;
    logic [127:0] x_fd, x_mwd;
    int idx;
    forever begin
      @(negedge clock);
      x_rst = reset; x_pop = sb_pop; x_wr = cache_wr_en; x_fill = cache_fill_en;
      x_addr = cache_addr; x_word = cache_wr_word; x_wd = cache_wr_data; x_be = cache_wr_bytes;
      x_fd = cache_fill_data; x_mv = mem_req_valid; x_mr = mem_req_ready; x_we = mem_req_we;
      x_maddr = mem_req_addr; x_mwd = mem_req_wdata;
      @(posedge clock);
      #1;
      idx = int'(x_addr[5:4]);
      acc = x_mv && x_mr && !x_rst;
      if (!x_rst) begin
        if (x_pop && sb_q.size() != 0) void'(sb_q.pop_front());
        if (x_wr) begin
          e_data[idx]  = put_word(e_data[idx], x_word, x_wd, x_be);
          e_dirty[idx] = 1'b1;
        end
        if (x_fill) begin
          e_valid[idx] = 1'b1; e_dirty[idx] = 1'b0; e_tag[idx] = x_addr[15:6]; e_data[idx] = x_fd;
        end
      end
      update_sb();
      mem_rvalid = 1'b0;
      if (rd_pend && auto_rvalid) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = e_mem.exists(int'(rd_addr)) ? e_mem[int'(rd_addr)] : mem_init(int'(rd_addr));
          rd_pend    = 1'b0;
          if (hold_on_rvalid) grant_low = 3;
        end else begin
          rd_cnt--;
        end
      end else if (!rd_pend && !acc && junk_en && $urandom_range(9) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (acc) begin
        if (x_we) begin
          e_mem[int'(x_maddr)] = x_mwd;
        end else begin
          rd_pend = 1'b1; rd_addr = x_maddr; rd_seen = 1'b1;
          rd_cnt  = int'($urandom_range(5));
        end
      end
      if (grant_low > 0) begin
        port_grant = 1'b0;
        grant_low--;
      end else begin
        port_grant = ($urandom_range(99) < grant_pct);
      end
      mem_req_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    int n;
    int issued;
    for (int i = 0; i < NL; i++) begin
      e_valid[i] = 1'b0; e_dirty[i] = 1'b0; e_tag[i] = '0; e_data[i] = '0;
      r_valid[i] = 1'b0; r_dirty[i] = 1'b0; r_tag[i] = '0; r_data[i] = '0;
    end
    grant_pct = 100; ready_pct = 50; grant_low = 0;
    auto_rvalid = 1'b1; junk_en = 1'b0; hold_on_rvalid = 1'b0;
    rd_pend = 1'b0; rd_seen = 1'b0; rd_cnt = 0; rd_addr = '0;
    reset = 1'b1; port_grant = 1'b1; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    sb_data = '0; sb_bytes = '0;
    update_sb();
    sb_tag = 16'h0abc;

    repeat (3) tick();
    @(negedge clock);
    chk("reset_outputs", {123'd0, sb_pop, cache_wr_en, cache_fill_en, mem_req_valid, busy}, 128'd0);
    chk("reset_addr_passthrough", {112'd0, cache_addr}, {112'd0, 16'h0abc});
    tick();
    reset = 1'b0;
    tick();

    // Single hit: pop and word write in the same cycle.
    preload(0, 10'd4, 1'b0, mem_init(16'h0100));
    issue(16'h0104, 32'hdeadbeef, 4'b1111);
    @(negedge clock);
    chk("hit_wr_en", {127'd0, cache_wr_en}, 128'd1);
    chk("hit_pop", {127'd0, sb_pop}, 128'd1);
    chk("hit_word", {126'd0, cache_wr_word}, 128'd1);
    tick();

    // Clean miss on an invalid line.
    issue(16'h0210, 32'h11223344, 4'b0101);
    wait_idle(300, "clean_miss");

    // Dirty miss: victim line 0x1200 written back before the read.
    preload(0, 10'h048, 1'b1, {4{32'hcafe1200}});
    issue(16'h0208, 32'ha5a5a5a5, 4'b1100);
    wait_idle(300, "dirty_miss");

    // Grant withheld for three cycles after read data returns.
    hold_on_rvalid = 1'b1;
    issue(16'h0224, 32'h0badf00d, 4'b1111);
    wait_idle(300, "fill_grant_hold");
    hold_on_rvalid = 1'b0;

    // Reset while waiting for read data.
    auto_rvalid = 1'b0;
    rd_seen = 1'b0;
    for (int i = 0; i < NL; i++) begin
      s_valid[i] = r_valid[i]; s_dirty[i] = r_dirty[i]; s_tag[i] = r_tag[i]; s_data[i] = r_data[i];
    end
    issue(16'h0230, 32'h99999999, 4'b1111);
    n = 0;
    while (!rd_seen && n < 100) begin
      tick();
      n++;
    end
    chk("reset_test_read_seen", {127'd0, rd_seen}, 128'd1);
    reset = 1'b1;
    sb_q.delete();
    update_sb();
    exp_q.delete();
    rd_pend = 1'b0;
    for (int i = 0; i < NL; i++) begin
      r_valid[i] = s_valid[i]; r_dirty[i] = s_dirty[i]; r_tag[i] = s_tag[i]; r_data[i] = s_data[i];
    end
    @(negedge clock);
    chk("reset_drops_req", {127'd0, mem_req_valid}, 128'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("reset_returns_lookup", {126'd0, busy, mem_req_valid}, 128'd0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = {4{32'hdeadd00d}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stale_rvalid_no_fill", {126'd0, cache_fill_en, busy}, 128'd0);
      tick();
    end
    auto_rvalid = 1'b1;

    // Three back-to-back hits, then a one-cycle grant gap.
    issue(16'h0210, 32'h00000001, 4'b1111);
    issue(16'h0214, 32'h00000002, 4'b0011);
    issue(16'h0218, 32'h00000003, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("b2b_pop", {127'd0, sb_pop}, 128'd1);
      tick();
    end
    issue(16'h0204, 32'h00000004, 4'b1111);
    issue(16'h021c, 32'h00000005, 4'b0110);
    port_grant = 1'b0;
    @(negedge clock);
    chk("no_grant_no_pop", {127'd0, sb_pop}, 128'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clock);
      chk("grant_resume_pop", {127'd0, sb_pop}, 128'd1);
    end
    tick();
    wait_idle(100, "directed_drain");

    // Randomized traffic over 4 tags x 4 lines x 4 words.
    grant_pct = 75; ready_pct = 50; junk_en = 1'b1;
    issued = 0; n = 0;
    while (issued < 300 && n < 30000) begin
      if (sb_q.size() < 3 && $urandom_range(1) == 1) begin
        issue(16'(($urandom_range(3) << 6) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2)),
              $urandom, 4'($urandom_range(15)));
        issued++;
      end
      tick();
      n++;
    end
    wait_idle(3000, "random_drain");
    junk_en = 1'b0;

    for (int i = 0; i < NL; i++) begin
      chk("final_line_state", {117'd0, e_valid[i], e_tag[i]}, {117'd0, r_valid[i], r_tag[i]});
      chk("final_line_data", e_data[i], r_data[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
